// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Central stall/flush controller for the 5-stage pipeline. It merges stall
//   requests from ID (load-use), EX (multi-cycle ops) and MEM (bus wait) plus
//   exception flushes into the 6-bit stall vector and the flush pulse.
//   It also owns the EX multi-cycle sequencer, so EX only pulses ex_start.
//
//   stall bit map: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB; 1 = hold.
//
//   Optional build macro STALL_PERF_EN: when defined, adds saturating
//   performance counters for stall cycles and flush pulses. When undefined,
//   both counter ports read constant zero and no counter flops exist.

module pipe_stall_ctrl #(
  parameter int CNT_W        = 6,
  parameter int DONE_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_id,
  input  logic             ex_start,
  input  logic [CNT_W-1:0] ex_cnt,
  input  logic             ex_done,
  input  logic             stallreq_mem,
  input  logic             flush_req,
  output logic [5:0]       stall,
  output logic             flush,
  output logic             ex_abort,
  output logic             ex_busy,
  output logic             timeout_err,
  output logic [31:0]      perf_stall_cycles,
  output logic [15:0]      perf_flush_count
);

  // Watchdog counter only has to reach DONE_TIMEOUT-2 (the last WAIT_DONE
  // cycle before the abort), so $clog2(DONE_TIMEOUT) bits are always enough.
  localparam int TMO_W = (DONE_TIMEOUT > 2) ? $clog2(DONE_TIMEOUT) : 1;

  // The start cycle is itself one stall cycle, so the last WAIT_DONE cycle is
  // the one where tmo would step to DONE_TIMEOUT-1; total stall is then
  // exactly DONE_TIMEOUT cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DONE_TIMEOUT - 2);

  // Stall levels: each source freezes its own stage and everything upstream.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EX_CNT    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt;
  logic [CNT_W-1:0]   rem_r;
  logic [CNT_W-1:0]   rem_nxt;
  logic [TMO_W-1:0]   tmo_r;
  logic [TMO_W-1:0]   tmo_nxt;
  logic               timeout_err_r;

  logic               ex_req;     // EX-level stall wanted this cycle
  logic               abort_s;    // in-flight op cancelled this cycle
  logic               tmo_fire;   // watchdog expires at this edge

  // Next-state logic of the EX multi-cycle sequencer; flush overrides all.
  always_comb begin
    state_nxt = state_r;
    rem_nxt   = rem_r;
    tmo_nxt   = tmo_r;
    ex_req    = 1'b0;
    abort_s   = 1'b0;
    tmo_fire  = 1'b0;

    if (flush_req) begin
      // Any ex_start seen in this cycle is dropped together with the op.
      state_nxt = IDLE;
      rem_nxt   = {CNT_W{1'b0}};
      tmo_nxt   = {TMO_W{1'b0}};
      abort_s   = (state_r != IDLE);
    end else begin
      case (state_r)
        IDLE: begin
          if (ex_start) begin
            ex_req = 1'b1;
            if (ex_cnt == {CNT_W{1'b0}}) begin
              state_nxt = WAIT_DONE;
              tmo_nxt   = {TMO_W{1'b0}};
            end else if (ex_cnt == CNT_W'(1)) begin
              // Single-cycle stall is covered by the start cycle alone.
              state_nxt = IDLE;
            end else begin
              state_nxt = EX_CNT;
              rem_nxt   = ex_cnt - CNT_W'(1);
            end
          end else begin
            // ex_done / ex_cnt without ex_start are ignored here.
            state_nxt = IDLE;
          end
        end

        EX_CNT: begin
          // Keeps counting through MEM stalls: the EX unit itself is running.
          ex_req = 1'b1;
          if (rem_r <= CNT_W'(1)) begin
            state_nxt = IDLE;
            rem_nxt   = {CNT_W{1'b0}};
          end else begin
            rem_nxt   = rem_r - CNT_W'(1);
          end
        end

        WAIT_DONE: begin
          if (ex_done) begin
            // Result is valid now, so EX is released in this very cycle.
            state_nxt = IDLE;
            tmo_nxt   = {TMO_W{1'b0}};
          end else begin
            ex_req = 1'b1;
            if (tmo_r == TMO_LAST) begin
              state_nxt = IDLE;
              tmo_nxt   = {TMO_W{1'b0}};
              abort_s   = 1'b1;
              tmo_fire  = 1'b1;
            end else begin
              tmo_nxt   = tmo_r + TMO_W'(1);
            end
          end
        end

        default: begin
          state_nxt = IDLE;
          rem_nxt   = {CNT_W{1'b0}};
          tmo_nxt   = {TMO_W{1'b0}};
        end
      endcase
    end
  end

  // Sequencer state, counters and the sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      rem_r         <= {CNT_W{1'b0}};
      tmo_r         <= {TMO_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      rem_r         <= rem_nxt;
      tmo_r         <= tmo_nxt;
      timeout_err_r <= timeout_err_r | tmo_fire;
    end
  end

  // Priority encode the stall sources; zero-latency to the requesting cycle.
  always_comb begin
    stall    = STALL_NONE;
    flush    = 1'b0;
    ex_abort = 1'b0;
    ex_busy  = 1'b0;

    if (rst) begin
      stall    = STALL_NONE;
      flush    = 1'b0;
      ex_abort = 1'b0;
      ex_busy  = 1'b0;
    end else begin
      ex_abort = abort_s;
      ex_busy  = (state_r != IDLE);
      if (flush_req) begin
        stall = STALL_NONE;
        flush = 1'b1;
      end else if (stallreq_mem) begin
        stall = STALL_MEM;
      end else if (ex_req) begin
        stall = STALL_EX;
      end else if (stallreq_id) begin
        stall = STALL_ID;
      end else begin
        stall = STALL_NONE;
      end
    end
  end

  assign timeout_err = timeout_err_r;

`ifdef STALL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [15:0] perf_flush_r;

  // Saturating counters of stalled cycles and issued flush pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 16'd0;
    end else begin
      if ((stall != STALL_NONE) && (perf_stall_r != {32{1'b1}})) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
      if (flush && (perf_flush_r != {16{1'b1}})) begin
        perf_flush_r <= perf_flush_r + 16'd1;
      end else begin
        perf_flush_r <= perf_flush_r;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_flush_count  = perf_flush_r;
`else
  assign perf_stall_cycles = 32'd0;
  assign perf_flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
//   Directed, table-driven bench for pipe_stall_ctrl. Each table row is one
//   clock cycle: inputs are driven after the falling edge and outputs are
//   compared 1 time unit later, well before the next rising edge.
//   Multi-cycle corner cases (watchdog, sticky error, perf counters) follow
//   as hand-written sequences.

module tb_pipe_stall_ctrl;

  localparam logic [5:0] S0 = 6'b000000;
  localparam logic [5:0] SI = 6'b000111;
  localparam logic [5:0] SE = 6'b001111;
  localparam logic [5:0] SM = 6'b011111;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id;
  logic        ex_start;
  logic [5:0]  ex_cnt;
  logic        ex_done;
  logic        stallreq_mem;
  logic        flush_req;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_abort;
  logic        ex_busy;
  logic        timeout_err;
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;

  pipe_stall_ctrl #(.CNT_W(6), .DONE_TIMEOUT(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_id       (stallreq_id),
    .ex_start          (ex_start),
    .ex_cnt            (ex_cnt),
    .ex_done           (ex_done),
    .stallreq_mem      (stallreq_mem),
    .flush_req         (flush_req),
    .stall             (stall),
    .flush             (flush),
    .ex_abort          (ex_abort),
    .ex_busy           (ex_busy),
    .timeout_err       (timeout_err),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       id;
    logic       st;
    logic [5:0] cnt;
    logic       dn;
    logic       mem;
    logic       fl;
    logic [5:0] e_stall;
    logic       e_fl;
    logic       e_ab;
    logic       e_busy;
    logic       e_terr;
  } vec_t;

  vec_t vecs [0:63];
  int   nvec  = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic add(input logic r, id, st, input logic [5:0] cnt,
                     input logic dn, mem, fl, input logic [5:0] e_stall,
                     input logic e_fl, e_ab, e_busy, e_terr);
    vecs[nvec] = '{r, id, st, cnt, dn, mem, fl, e_stall, e_fl, e_ab, e_busy, e_terr};
    nvec++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, id, st, input logic [5:0] cnt,
                       input logic dn, mem, fl);
    @(negedge clk);
    rst = r; stallreq_id = id; ex_start = st; ex_cnt = cnt;
    ex_done = dn; stallreq_mem = mem; flush_req = fl;
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [5:0] e_stall,
                            input logic e_fl, e_ab, e_busy, e_terr);
    chk({tag, ".stall"},       {26'd0, stall},       {26'd0, e_stall});
    chk({tag, ".flush"},       {31'd0, flush},       {31'd0, e_fl});
    chk({tag, ".ex_abort"},    {31'd0, ex_abort},    {31'd0, e_ab});
    chk({tag, ".ex_busy"},     {31'd0, ex_busy},     {31'd0, e_busy});
    chk({tag, ".timeout_err"}, {31'd0, timeout_err}, {31'd0, e_terr});
  endtask

  initial begin
    logic [31:0] exp_ps;
    logic [15:0] exp_fc;

    rst = 1'b1; stallreq_id = 1'b0; ex_start = 1'b0; ex_cnt = 6'd0;
    ex_done = 1'b0; stallreq_mem = 1'b0; flush_req = 1'b0;

    //   r     id    st    cnt    dn    mem   fl     stall fl    ab    busy  terr
    // reset gates every output even with requests present
    add(1'b1, 1'b1, 1'b1, 6'd4, 1'b0, 1'b1, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // load-use stall for a single cycle
    add(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  SI, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // fixed op, ex_cnt=4: four EX stalls, busy for the last three; ID masked
    add(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // ex_cnt=1: stall in the start cycle only
    add(1'b0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // ex_done / ex_cnt without ex_start in IDLE do nothing
    add(1'b0, 1'b0, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // handshake op: done arrives 10 cycles after start
    add(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++)
      add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, SE, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // ex_start while busy is dropped; MEM overrides EX while counting
    add(1'b0, 1'b0, 1'b1, 6'd3, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0,  SM, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,  SM, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // EX_CNT rem=5: two MEM cycles, then flush aborts
    add(1'b0, 1'b0, 1'b1, 6'd6, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,  SM, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0,  SM, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1,  S0, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // flush in IDLE discards a simultaneous ex_start, no abort
    add(1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1, 1'b1,  S0, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // flush during WAIT_DONE aborts
    add(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1,  S0, 1'b1, 1'b1, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // ex_done honoured under a concurrent MEM stall
    add(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0,  SM, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    // done releases EX in the same cycle; an ID request then shows through
    add(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 6'd0, 1'b1, 1'b0, 1'b0,  SI, 1'b0, 1'b0, 1'b1, 1'b0);
    // rst mid-operation: silent return to IDLE
    add(1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0,  SE, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0,  S0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].r, vecs[i].id, vecs[i].st, vecs[i].cnt,
            vecs[i].dn, vecs[i].mem, vecs[i].fl);
      check_outs($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_fl,
                 vecs[i].e_ab, vecs[i].e_busy, vecs[i].e_terr);
    end

    // Watchdog: 64 stalled cycles in total, abort on the last of them.
    drive(1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0);
    check_outs("to_start", SE, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 63; k++) begin
      drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
      check_outs($sformatf("to_wait%0d", k), SE, 1'b0, (k == 62), 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_outs("to_release", S0, 1'b0, 1'b0, 1'b0, 1'b1);
    // error stays set across later, normal operations
    drive(1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
    check_outs("sticky_a", SE, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_outs("sticky_b", SE, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    check_outs("sticky_c", S0, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_stall", {26'd0, stall}, {26'd0, S0});
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    check_outs("after_rst", S0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("perf_stall_rst", perf_stall_cycles, 32'd0);
    chk("perf_flush_rst", {16'd0, perf_flush_count}, 32'd0);

    // Perf counters: ex_cnt=4 op plus one flush.
    drive(1'b0, 1'b0, 1'b1, 6'd4, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
`ifdef STALL_PERF_EN
    exp_ps = 32'd4;
    exp_fc = 16'd1;
`else
    exp_ps = 32'd0;
    exp_fc = 16'd0;
`endif
    chk("perf_stall_cycles", perf_stall_cycles, exp_ps);
    chk("perf_flush_count", {16'd0, perf_flush_count}, {16'd0, exp_fc});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
